// File: rtl/symbol_mux_ser.sv
`default_nettype none
// ============================================================================
// Module   : symbol_mux_ser
// Purpose  : Byte-to-symbol serializer. Each accepted byte is emitted as two
//            4-bit symbols; a new byte can load during the last symbol.
// Revision : 1.0  initial release
// ============================================================================
module symbol_mux_ser #(
    parameter int LSN_FIRST = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       inByte,
    input  logic             inByteValid,
    input  logic             inByteLast,
    output logic             outByteReady,
    output logic [3:0]       outSym,
    output logic             outSymValid,
    output logic             outSymLast,
    input  logic             inSymReady,
    output logic             outSymIdx,
    output logic [CNT_W-1:0] outSymCnt
);

    localparam logic [1:0]       c_ST_EMPTY = 2'd0;
    localparam logic [1:0]       c_ST_S0    = 2'd1;
    localparam logic [1:0]       c_ST_S1    = 2'd2;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [7:0]       r_byte;
    logic             r_last;
    logic [CNT_W-1:0] r_sym_cnt;
    logic             w_byte_xfer;
    logic             w_sym_xfer;
    logic [3:0]       w_first_nib;
    logic [3:0]       w_second_nib;

    // Both handshakes are built from the reset-gated outputs, so neither can
    // fire while reset is high.
    assign w_byte_xfer  = inByteValid && outByteReady;
    assign w_sym_xfer   = outSymValid && inSymReady;
    assign w_first_nib  = (LSN_FIRST != 0) ? r_byte[3:0] : r_byte[7:4];
    assign w_second_nib = (LSN_FIRST != 0) ? r_byte[7:4] : r_byte[3:0];
    assign outSymCnt    = r_sym_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_EMPTY: if (w_byte_xfer) w_state_next = c_ST_S0;
            c_ST_S0:    if (w_sym_xfer)  w_state_next = c_ST_S1;
            c_ST_S1:    if (w_sym_xfer)  w_state_next = w_byte_xfer ? c_ST_S0 : c_ST_EMPTY;
            default:    w_state_next = c_ST_EMPTY;
        endcase
    end

    // Only outByteReady looks at inSymReady; symbol outputs decode state alone.
    always_comb begin
        outByteReady = 1'b0;
        outSymValid  = 1'b0;
        outSym       = 4'h0;
        outSymIdx    = 1'b0;
        outSymLast   = 1'b0;
        if (!reset) begin
            outByteReady = (r_state == c_ST_EMPTY) || ((r_state == c_ST_S1) && inSymReady);
            case (r_state)
                c_ST_S0: begin
                    outSymValid = 1'b1;
                    outSym      = w_first_nib;
                end
                c_ST_S1: begin
                    outSymValid = 1'b1;
                    outSym      = w_second_nib;
                    outSymIdx   = 1'b1;
                    outSymLast  = r_last;
                end
                default: begin
                    outSymValid = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte    <= 8'h00;
            r_last    <= 1'b0;
            r_sym_cnt <= '0;
        end else begin
            if (w_byte_xfer) begin
                r_byte <= inByte;
                r_last <= inByteLast;
            end
            if (w_sym_xfer) begin
                r_sym_cnt <= r_sym_cnt + c_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_symbol_mux_ser.sv
`default_nettype none
// ============================================================================
// Module   : tb_symbol_mux_ser
// Purpose  : Directed self-checking bench for symbol_mux_ser (three variants).
// Revision : 1.0  initial release
// ============================================================================
module tb_symbol_mux_ser;

    logic       clk;
    logic       reset;
    logic [7:0] inByte;
    logic       inByteValid;
    logic       inByteLast;
    logic       inSymReady;

    logic        a_rdy, a_valid, a_last, a_idx;
    logic [3:0]  a_sym;
    logic [15:0] a_cnt;
    logic        b_rdy, b_valid, b_last, b_idx;
    logic [3:0]  b_sym;
    logic [15:0] b_cnt;
    logic        c_rdy, c_valid, c_last, c_idx;
    logic [3:0]  c_sym;
    logic [3:0]  c_cnt;

    int n_checks;
    int n_pass;

    symbol_mux_ser #(.LSN_FIRST(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .inByte(inByte), .inByteValid(inByteValid),
        .inByteLast(inByteLast), .outByteReady(a_rdy), .outSym(a_sym),
        .outSymValid(a_valid), .outSymLast(a_last), .inSymReady(inSymReady),
        .outSymIdx(a_idx), .outSymCnt(a_cnt)
    );

    symbol_mux_ser #(.LSN_FIRST(0), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .inByte(inByte), .inByteValid(inByteValid),
        .inByteLast(inByteLast), .outByteReady(b_rdy), .outSym(b_sym),
        .outSymValid(b_valid), .outSymLast(b_last), .inSymReady(inSymReady),
        .outSymIdx(b_idx), .outSymCnt(b_cnt)
    );

    symbol_mux_ser #(.LSN_FIRST(1), .CNT_W(4)) dut_c (
        .clk(clk), .reset(reset), .inByte(inByte), .inByteValid(inByteValid),
        .inByteLast(inByteLast), .outByteReady(c_rdy), .outSym(c_sym),
        .outSymValid(c_valid), .outSymLast(c_last), .inSymReady(inSymReady),
        .outSymIdx(c_idx), .outSymCnt(c_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        inByteValid = 1'b0;
        inByteLast  = 1'b0;
        inByte      = 8'h00;
        inSymReady  = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset_single();
        reset       = 1'b1;
        inByteValid = 1'b1;
        inByte      = 8'hFF;
        inByteLast  = 1'b0;
        inSymReady  = 1'b1;
        cyc();
        cyc();
        #1;
        n_checks++; if ({a_rdy, a_valid, a_sym, a_idx, a_last} !== 8'h00) $display("FAIL reset_outputs got %h want 00", {a_rdy, a_valid, a_sym, a_idx, a_last}); else n_pass++;
        reset       = 1'b0;
        inByteValid = 1'b0;
        #1;
        n_checks++; if (a_rdy !== 1'b1) $display("FAIL ready_after_reset got %b want 1", a_rdy); else n_pass++;
        n_checks++; if (a_cnt !== 16'd0) $display("FAIL cnt_after_reset got %0d want 0", a_cnt); else n_pass++;
        inByte      = 8'hA5;
        inByteValid = 1'b1;
        inByteLast  = 1'b1;
        cyc();
        inByteValid = 1'b0;
        inByteLast  = 1'b0;
        #1;
        n_checks++; if ({a_valid, a_sym, a_idx, a_last, a_rdy} !== {1'b1, 4'h5, 1'b0, 1'b0, 1'b0}) $display("FAIL single_s0 got v%b s%h i%b l%b r%b want v1 s5 i0 l0 r0", a_valid, a_sym, a_idx, a_last, a_rdy); else n_pass++;
        cyc();
        n_checks++; if ({a_valid, a_sym, a_idx, a_last} !== {1'b1, 4'hA, 1'b1, 1'b1}) $display("FAIL single_s1 got v%b s%h i%b l%b want v1 sa i1 l1", a_valid, a_sym, a_idx, a_last); else n_pass++;
        cyc();
        n_checks++; if (a_valid !== 1'b0) $display("FAIL single_empty got %b want 0", a_valid); else n_pass++;
        n_checks++; if (a_cnt !== 16'd2) $display("FAIL single_cnt got %0d want 2", a_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        logic [3:0] exp_sym [6];
        bytes   = '{8'hA5, 8'h3C, 8'hF0};
        exp_sym = '{4'h5, 4'hA, 4'hC, 4'h3, 4'h0, 4'hF};
        inByte      = bytes[0];
        inByteValid = 1'b1;
        inSymReady  = 1'b1;
        cyc();
        for (int i = 0; i < 6; i++) begin
            if (i / 2 + 1 < 3) inByte = bytes[i / 2 + 1];
            else inByteValid = 1'b0;
            #1;
            n_checks++; if ({a_valid, a_sym} !== {1'b1, exp_sym[i]}) $display("FAIL b2b_sym%0d got v%b s%h want v1 s%h", i, a_valid, a_sym, exp_sym[i]); else n_pass++;
            if ((i % 2) == 1) begin
                n_checks++; if (a_rdy !== 1'b1) $display("FAIL b2b_ready%0d got %b want 1", i, a_rdy); else n_pass++;
            end
            cyc();
        end
        n_checks++; if (a_valid !== 1'b0) $display("FAIL b2b_empty got %b want 0", a_valid); else n_pass++;
        n_checks++; if (a_cnt !== 16'd8) $display("FAIL b2b_cnt got %0d want 8", a_cnt); else n_pass++;
    endtask

    task automatic test_backpressure();
        inByte      = 8'h12;
        inByteValid = 1'b1;
        inSymReady  = 1'b1;
        cyc();
        inByte     = 8'hFF;
        inSymReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if ({a_valid, a_sym, a_idx, a_rdy} !== {1'b1, 4'h2, 1'b0, 1'b0}) $display("FAIL bp_hold%0d got v%b s%h i%b r%b want v1 s2 i0 r0", i, a_valid, a_sym, a_idx, a_rdy); else n_pass++;
            cyc();
        end
        inByteValid = 1'b0;
        inSymReady  = 1'b1;
        #1;
        n_checks++; if (a_sym !== 4'h2) $display("FAIL bp_first got %h want 2", a_sym); else n_pass++;
        cyc();
        n_checks++; if ({a_valid, a_sym, a_idx, a_last} !== {1'b1, 4'h1, 1'b1, 1'b0}) $display("FAIL bp_second got v%b s%h i%b l%b want v1 s1 i1 l0", a_valid, a_sym, a_idx, a_last); else n_pass++;
        cyc();
        n_checks++; if (a_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", a_valid); else n_pass++;
        n_checks++; if (a_cnt !== 16'd10) $display("FAIL bp_cnt got %0d want 10", a_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_byte();
        inByte      = 8'h7E;
        inByteValid = 1'b1;
        inSymReady  = 1'b1;
        cyc();
        inByteValid = 1'b0;
        #1;
        n_checks++; if (a_sym !== 4'hE) $display("FAIL mid_first got %h want e", a_sym); else n_pass++;
        cyc();
        reset = 1'b1;
        #1;
        n_checks++; if ({a_rdy, a_valid, a_sym, a_idx, a_last} !== 8'h00) $display("FAIL mid_reset_outputs got %h want 00", {a_rdy, a_valid, a_sym, a_idx, a_last}); else n_pass++;
        cyc();
        reset = 1'b0;
        #1;
        n_checks++; if ({a_valid, a_cnt} !== 17'd0) $display("FAIL mid_after_reset got v%b c%0d want v0 c0", a_valid, a_cnt); else n_pass++;
        inByte      = 8'h44;
        inByteValid = 1'b1;
        cyc();
        inByteValid = 1'b0;
        #1;
        n_checks++; if ({a_valid, a_sym, a_idx} !== {1'b1, 4'h4, 1'b0}) $display("FAIL mid_new_s0 got v%b s%h i%b want v1 s4 i0", a_valid, a_sym, a_idx); else n_pass++;
        cyc();
        n_checks++; if ({a_valid, a_sym, a_idx} !== {1'b1, 4'h4, 1'b1}) $display("FAIL mid_new_s1 got v%b s%h i%b want v1 s4 i1", a_valid, a_sym, a_idx); else n_pass++;
        cyc();
        n_checks++; if (a_cnt !== 16'd2) $display("FAIL mid_cnt got %0d want 2", a_cnt); else n_pass++;
    endtask

    task automatic test_msn_first();
        do_reset();
        inByte      = 8'hA5;
        inByteValid = 1'b1;
        inByteLast  = 1'b1;
        cyc();
        inByteValid = 1'b0;
        inByteLast  = 1'b0;
        #1;
        n_checks++; if ({b_valid, b_sym, b_idx} !== {1'b1, 4'hA, 1'b0}) $display("FAIL msn_s0 got v%b s%h i%b want v1 sa i0", b_valid, b_sym, b_idx); else n_pass++;
        cyc();
        n_checks++; if ({b_valid, b_sym, b_idx, b_last} !== {1'b1, 4'h5, 1'b1, 1'b1}) $display("FAIL msn_s1 got v%b s%h i%b l%b want v1 s5 i1 l1", b_valid, b_sym, b_idx, b_last); else n_pass++;
        cyc();
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        inByte      = 8'h00;
        inByteValid = 1'b1;
        inSymReady  = 1'b1;
        cyc();
        for (int i = 0; i < 18; i++) begin
            inByte = 8'((i / 2) + 1);
            if (i >= 16) inByteValid = 1'b0;
            #1;
            cyc();
        end
        n_checks++; if (c_valid !== 1'b0) $display("FAIL wrap_empty got %b want 0", c_valid); else n_pass++;
        n_checks++; if (c_cnt !== 4'd2) $display("FAIL wrap_cnt4 got %0d want 2", c_cnt); else n_pass++;
        n_checks++; if (a_cnt !== 16'd18) $display("FAIL wrap_cnt16 got %0d want 18", a_cnt); else n_pass++;
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        reset       = 1'b1;
        inByte      = 8'h00;
        inByteValid = 1'b0;
        inByteLast  = 1'b0;
        inSymReady  = 1'b1;
        test_reset_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_byte();
        test_msn_first();
        test_cnt_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
